// File: rtl/sparc_ctrl_pkg.sv
// Shared definitions for the SPARC hardwired control unit.
//   - state_t: 5-bit FSM state encoding (also exported on State_o for debug)
//   - IR field constants for op / op2 / op3 decode
//   - ALU opcodes, access type, mux-select encodings
//   - ctrl_t: bundle of every per-cycle datapath control
package sparc_ctrl_pkg;

  localparam int unsigned MOC_TIMEOUT = 16;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_PASSA = 6'b001101;
  localparam logic [5:0] OP_PASSB = 6'b001110;
  localparam logic [1:0] TYPE_WORD = 2'b00;

  // IR[31:30]
  localparam logic [1:0] OP_FMT2  = 2'b00;
  localparam logic [1:0] OP_CALL  = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;
  localparam logic [1:0] OP_MEM   = 2'b11;
  // IR[24:22] / IR[24:19]
  localparam logic [2:0] OP2_SETHI = 3'b100;
  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [5:0] OP3_TICC  = 6'b111010;

  localparam logic [1:0] MA_RS1   = 2'b00;
  localparam logic [1:0] MA_TBR   = 2'b11;
  localparam logic [1:0] MB_PORTB = 2'b00;
  localparam logic [1:0] MB_IMM   = 2'b01;
  localparam logic [1:0] MB_MUXC  = 2'b10;
  localparam logic [1:0] MB_MDR   = 2'b11;
  localparam logic       MC_PC    = 1'b0;
  localparam logic       MC_NPC   = 1'b1;
  localparam logic [1:0] MNP_ALU  = 2'b00;
  localparam logic [1:0] MNP_NPC8 = 2'b01;
  localparam logic [1:0] MNP_DISP = 2'b10;
  localparam logic [1:0] MNP_NPC4 = 2'b11;
  localparam logic [1:0] MP_ZERO  = 2'b00;
  localparam logic [1:0] MP_TBR   = 2'b01;
  localparam logic [1:0] MP_NPC4  = 2'b10;
  localparam logic [1:0] MP_NPC   = 2'b11;
  localparam logic [1:0] MSC_RD   = 2'b00;
  localparam logic [1:0] MSC_R15  = 2'b01;
  localparam logic [1:0] MSC_R17  = 2'b10;
  localparam logic [1:0] MSC_R18  = 2'b11;

  typedef enum logic [4:0] {
    S_INIT, S_F0, S_F1, S_DEC, S_ALU, S_SETHI, S_ADV, S_LSA, S_LDM, S_LDW,
    S_STD, S_STM, S_BR, S_CALL0, S_CALL1, S_TICC,
    S_TRAP0, S_TRAP1, S_TRAP2, S_TRAP3
  } state_t;

  typedef struct packed {
    logic       rf_ld;
    logic       ir_ld;
    logic       mar_ld;
    logic       mdr_ld;
    logic       pc_ld;
    logic       npc_ld;
    logic       fr_ld;
    logic       rw;
    logic       mov;
    logic [1:0] ma;
    logic [1:0] mb;
    logic [1:0] mnp;
    logic [1:0] mp;
    logic [1:0] msc;
    logic       mc;
    logic       mm;
    logic       mop;
    logic       msa;
    logic [5:0] opxx;
  } ctrl_t;

endpackage

// File: rtl/sparc_moc_timer.sv
// Memory-handshake watchdog counter.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : restart count at zero (wins over en_i)
//   en_i          : count this cycle (saturating)
//   expired_o     : count has reached LIMIT-1
module sparc_moc_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(LIMIT) + 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/sparc_control_unit.sv
// Hardwired control FSM sitting directly upstream of the SPARC datapath.
// Inputs : Clk_i, Clr_n_i (async active-low), IR_i, MOC_i, BCOND_i, TCOND_i
// Outputs: register-file / register-load strobes, memory controls (RW, MOV,
//          type), mux selects (MA..MSa), forced ALU opcode OpXX, debug State.
// Outputs are decoded from the current state each cycle; the few that also
// depend on MOC/BCOND are qualified combinationally so the load happens on
// the same edge the condition is seen.
module sparc_control_unit
  import sparc_ctrl_pkg::*;
(
  input  logic        Clk_i,
  input  logic        Clr_n_i,
  input  logic [31:0] IR_i,
  input  logic        MOC_i,
  input  logic        BCOND_i,
  input  logic        TCOND_i,
  output logic        Register_Windows_Enable_o,
  output logic        RF_Load_Enable_o,
  output logic        RF_Clear_Enable_o,
  output logic        IR_Ld_o,
  output logic        MAR_Ld_o,
  output logic        MDR_Ld_o,
  output logic        WIM_Ld_o,
  output logic        TBR_Ld_o,
  output logic        TTR_Ld_o,
  output logic        PC_Ld_o,
  output logic        NPC_Ld_o,
  output logic        PSR_Ld_o,
  output logic        FR_Ld_o,
  output logic        nPC_Clr_o,
  output logic        RW_o,
  output logic        MOV_o,
  output logic [1:0]  type_o,
  output logic [1:0]  MA_o,
  output logic [1:0]  MB_o,
  output logic [1:0]  MNP_o,
  output logic [1:0]  MP_o,
  output logic [1:0]  MSc_o,
  output logic        MC_o,
  output logic        MF_o,
  output logic        MM_o,
  output logic        MOP_o,
  output logic        MSa_o,
  output logic [5:0]  OpXX_o,
  output logic [4:0]  State_o
);

  state_t state_q, state_d;
  ctrl_t  ctl;
  logic   tmo_expired, tmo_clr, mem_state;

  wire [1:0] op  = IR_i[31:30];
  wire [2:0] op2 = IR_i[24:22];
  wire [5:0] op3 = IR_i[24:19];
  logic unused_ir;
  assign unused_ir = ^{IR_i[28:25], IR_i[18:14], IR_i[12:0]};

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    case (state_q)
      S_INIT: begin
        ctl.pc_ld = 1'b1; ctl.mp = MP_ZERO; ctl.npc_ld = 1'b1; ctl.mnp = MNP_NPC4;
        state_d = S_F0;
      end
      S_F0: begin
        ctl.mc = MC_PC; ctl.mb = MB_MUXC; ctl.mop = 1'b1; ctl.opxx = OP_PASSB;
        ctl.mar_ld = 1'b1;
        state_d = S_F1;
      end
      S_F1: begin
        ctl.mov = 1'b1; ctl.rw = 1'b1;
        if (MOC_i) begin
          ctl.ir_ld = 1'b1;
          state_d   = S_DEC;
        end else if (tmo_expired) state_d = S_TRAP0;
      end
      S_DEC: begin
        case (op)
          OP_CALL:  state_d = S_CALL0;
          OP_ARITH: state_d = (op3 == OP3_TICC) ? S_TICC : S_ALU;
          OP_MEM:   state_d = S_LSA;
          default:  state_d = (op2 == OP2_SETHI) ? S_SETHI :
                              (op2 == OP2_BICC)  ? S_BR : S_TRAP0;
        endcase
      end
      S_ALU: begin
        ctl.msa = 1'b0; ctl.ma = MA_RS1; ctl.mb = {1'b0, IR_i[13]}; ctl.mop = 1'b0;
        ctl.msc = MSC_RD; ctl.rf_ld = 1'b1; ctl.fr_ld = op3[4];
        state_d = S_ADV;
      end
      S_SETHI: begin
        ctl.mb = MB_IMM; ctl.mop = 1'b1; ctl.opxx = OP_PASSB; ctl.msc = MSC_RD;
        ctl.rf_ld = 1'b1;
        state_d = S_ADV;
      end
      S_ADV: begin
        ctl.pc_ld = 1'b1; ctl.mp = MP_NPC; ctl.npc_ld = 1'b1; ctl.mnp = MNP_NPC4;
        state_d = S_F0;
      end
      S_LSA: begin
        ctl.msa = 1'b0; ctl.mb = {1'b0, IR_i[13]}; ctl.mop = 1'b1; ctl.opxx = OP_ADD;
        ctl.mar_ld = 1'b1;
        state_d = op3[2] ? S_STD : S_LDM;
      end
      S_LDM: begin
        ctl.mov = 1'b1; ctl.rw = 1'b1;
        if (MOC_i) begin
          ctl.mdr_ld = 1'b1; ctl.mm = 1'b0;
          state_d = S_LDW;
        end else if (tmo_expired) state_d = S_TRAP0;
      end
      S_LDW: begin
        ctl.mb = MB_MDR; ctl.mop = 1'b1; ctl.opxx = OP_PASSB; ctl.msc = MSC_RD;
        ctl.rf_ld = 1'b1;
        state_d = S_ADV;
      end
      S_STD: begin
        ctl.msa = 1'b1; ctl.ma = MA_RS1; ctl.mop = 1'b1; ctl.opxx = OP_PASSA;
        ctl.mm = 1'b1; ctl.mdr_ld = 1'b1;
        state_d = S_STM;
      end
      S_STM: begin
        ctl.mov = 1'b1; ctl.rw = 1'b0;
        if (MOC_i)            state_d = S_ADV;
        else if (tmo_expired) state_d = S_TRAP0;
      end
      S_BR: begin
        // PC/NPC are loaded in every case; only the sources differ.
        ctl.pc_ld = 1'b1; ctl.npc_ld = 1'b1;
        if (BCOND_i) begin
          ctl.mp = MP_NPC;  ctl.mnp = MNP_DISP;
        end else if (IR_i[29]) begin
          ctl.mp = MP_NPC4; ctl.mnp = MNP_NPC8;
        end else begin
          ctl.mp = MP_NPC;  ctl.mnp = MNP_NPC4;
        end
        state_d = S_F0;
      end
      S_CALL0: begin
        ctl.mc = MC_PC; ctl.mb = MB_MUXC; ctl.mop = 1'b1; ctl.opxx = OP_PASSB;
        ctl.msc = MSC_R15; ctl.rf_ld = 1'b1;
        state_d = S_CALL1;
      end
      S_CALL1: begin
        ctl.pc_ld = 1'b1; ctl.mp = MP_NPC; ctl.npc_ld = 1'b1; ctl.mnp = MNP_DISP;
        state_d = S_F0;
      end
      S_TICC: state_d = TCOND_i ? S_TRAP0 : S_ADV;
      S_TRAP0, S_TRAP1: begin
        ctl.mc  = (state_q == S_TRAP1) ? MC_NPC : MC_PC;
        ctl.msc = (state_q == S_TRAP1) ? MSC_R18 : MSC_R17;
        ctl.mb = MB_MUXC; ctl.opxx = OP_PASSB; ctl.mop = 1'b1; ctl.rf_ld = 1'b1;
        state_d = (state_q == S_TRAP1) ? S_TRAP2 : S_TRAP1;
      end
      S_TRAP2: begin
        ctl.pc_ld = 1'b1; ctl.mp = MP_TBR; ctl.ma = MA_TBR; ctl.mop = 1'b1;
        ctl.opxx = OP_PASSA; ctl.npc_ld = 1'b1; ctl.mnp = MNP_ALU;
        state_d = S_TRAP3;
      end
      S_TRAP3: begin
        ctl.npc_ld = 1'b1; ctl.mnp = MNP_NPC4;
        state_d = S_F0;
      end
      default: state_d = S_INIT;
    endcase
    // Reset drops everything at once, including MOV of an access in flight.
    if (!Clr_n_i) ctl = '0;
  end

  always_ff @(posedge Clk_i or negedge Clr_n_i) begin
    if (!Clr_n_i) state_q <= S_INIT;
    else          state_q <= state_d;
  end

  assign mem_state = (state_d == S_F1) || (state_d == S_LDM) || (state_d == S_STM);
  assign tmo_clr   = mem_state && (state_d != state_q);

  sparc_moc_timer #(.LIMIT(MOC_TIMEOUT)) u_moc_timer (
    .clk_i     (Clk_i),
    .rst_ni    (Clr_n_i),
    .clr_i     (tmo_clr),
    .en_i      (ctl.mov && !MOC_i),
    .expired_o (tmo_expired)
  );

  assign Register_Windows_Enable_o = Clr_n_i;
  assign nPC_Clr_o         = !Clr_n_i;
  assign RF_Clear_Enable_o = 1'b0;
  assign WIM_Ld_o          = 1'b0;
  assign TBR_Ld_o          = 1'b0;
  assign TTR_Ld_o          = 1'b0;
  assign PSR_Ld_o          = 1'b0;
  assign MF_o              = 1'b0;
  assign type_o            = TYPE_WORD;
  assign RF_Load_Enable_o  = ctl.rf_ld;
  assign IR_Ld_o           = ctl.ir_ld;
  assign MAR_Ld_o          = ctl.mar_ld;
  assign MDR_Ld_o          = ctl.mdr_ld;
  assign PC_Ld_o           = ctl.pc_ld;
  assign NPC_Ld_o          = ctl.npc_ld;
  assign FR_Ld_o           = ctl.fr_ld;
  assign RW_o              = ctl.rw;
  assign MOV_o             = ctl.mov;
  assign MA_o              = ctl.ma;
  assign MB_o              = ctl.mb;
  assign MNP_o             = ctl.mnp;
  assign MP_o              = ctl.mp;
  assign MSc_o             = ctl.msc;
  assign MC_o              = ctl.mc;
  assign MM_o              = ctl.mm;
  assign MOP_o             = ctl.mop;
  assign MSa_o             = ctl.msa;
  assign OpXX_o            = ctl.opxx;
  assign State_o           = state_q;

endmodule

// File: tb/tb_sparc_control_unit.sv
module tb_sparc_control_unit;

  localparam logic [4:0] S_INIT = 5'd0,  S_F0 = 5'd1,  S_F1 = 5'd2,  S_DEC = 5'd3,
                         S_ALU = 5'd4,  S_SETHI = 5'd5, S_ADV = 5'd6, S_LSA = 5'd7,
                         S_LDM = 5'd8,  S_LDW = 5'd9,  S_STD = 5'd10, S_STM = 5'd11,
                         S_BR = 5'd12,  S_CALL0 = 5'd13, S_CALL1 = 5'd14, S_TICC = 5'd15,
                         S_TRAP0 = 5'd16, S_TRAP1 = 5'd17, S_TRAP2 = 5'd18, S_TRAP3 = 5'd19;

  logic Clk = 1'b0, Clr_n = 1'b0;
  logic [31:0] IR = '0;
  logic MOC = 1'b0, BCOND = 1'b0, TCOND = 1'b0;
  logic RWE, RF_Ld, RF_Clr, IR_Ld, MAR_Ld, MDR_Ld, WIM_Ld, TBR_Ld, TTR_Ld;
  logic PC_Ld, NPC_Ld, PSR_Ld, FR_Ld, nPC_Clr, RW, MOV;
  logic [1:0] typ, MA, MB, MNP, MP, MSc;
  logic MC, MF, MM, MOP, MSa;
  logic [5:0] OpXX;
  logic [4:0] State;

  int n_vec = 0;
  int n_err = 0;

  sparc_control_unit dut (
    .Clk_i(Clk), .Clr_n_i(Clr_n), .IR_i(IR), .MOC_i(MOC), .BCOND_i(BCOND), .TCOND_i(TCOND),
    .Register_Windows_Enable_o(RWE), .RF_Load_Enable_o(RF_Ld), .RF_Clear_Enable_o(RF_Clr),
    .IR_Ld_o(IR_Ld), .MAR_Ld_o(MAR_Ld), .MDR_Ld_o(MDR_Ld), .WIM_Ld_o(WIM_Ld),
    .TBR_Ld_o(TBR_Ld), .TTR_Ld_o(TTR_Ld), .PC_Ld_o(PC_Ld), .NPC_Ld_o(NPC_Ld),
    .PSR_Ld_o(PSR_Ld), .FR_Ld_o(FR_Ld), .nPC_Clr_o(nPC_Clr), .RW_o(RW), .MOV_o(MOV),
    .type_o(typ), .MA_o(MA), .MB_o(MB), .MNP_o(MNP), .MP_o(MP), .MSc_o(MSc),
    .MC_o(MC), .MF_o(MF), .MM_o(MM), .MOP_o(MOP), .MSa_o(MSa), .OpXX_o(OpXX),
    .State_o(State)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  // Starts in S_F0, ends in S_DEC; MOC arrives after wait_cyc idle F1 cycles.
  task automatic fetch(input logic [31:0] ir, input int wait_cyc);
    chk("f0_state", State, S_F0);
    chk("f0_ctl", {MAR_Ld, MC, MB, MOP, OpXX}, {1'b1, 1'b0, 2'b10, 1'b1, 6'b001110});
    step();
    for (int i = 0; i < wait_cyc; i++) begin
      chk("f1_wait", {State, MOV, RW, IR_Ld}, {S_F1, 3'b110});
      step();
    end
    IR = ir; MOC = 1'b1; #1;
    chk("f1_irld", {State, MOV, RW, IR_Ld}, {S_F1, 3'b111});
    step();
    MOC = 1'b0; #1;
    chk("dec_state", State, S_DEC);
  endtask

  initial begin
    // Power-on reset.
    @(negedge Clk); @(negedge Clk); #1;
    chk("rst_state", State, S_INIT);
    chk("rst_outs", {nPC_Clr, RWE, MOV, PC_Ld, NPC_Ld, RF_Ld}, 6'b100000);
    @(negedge Clk); Clr_n = 1'b1; #1;
    chk("init_ctl", {State, PC_Ld, MP, NPC_Ld, MNP, nPC_Clr, RWE}, {S_INIT, 1'b1, 2'b00, 1'b1, 2'b11, 1'b0, 1'b1});
    step();
    chk("f0_after_init", State, S_F0);
    step();
    chk("f1_mov", {State, MOV, RW}, {S_F1, 2'b11});
    // Reset in the middle of a fetch access.
    Clr_n = 1'b0; #1;
    chk("midrst_mov", {MOV, nPC_Clr, State}, {1'b0, 1'b1, S_INIT});
    @(negedge Clk); Clr_n = 1'b1; #1;
    chk("midrst_init", {State, PC_Ld, MP}, {S_INIT, 1'b1, 2'b00});
    step();

    // ADD r3,r1,r2
    fetch(32'h86004002, 2);
    step();
    chk("alu_ctl", {State, MB, RF_Ld, MOP, MSc, FR_Ld}, {S_ALU, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0});
    step();
    chk("adv_ctl", {State, PC_Ld, MP, NPC_Ld, MNP}, {S_ADV, 1'b1, 2'b11, 1'b1, 2'b11});
    step();

    // LD [r1+8],r4 with MOC on the last cycle before timeout (MOC must win).
    fetch(32'hC8006008, 0);
    step();
    chk("lsa_ctl", {State, OpXX, MB, MOP, MAR_Ld}, {S_LSA, 6'b000000, 2'b01, 1'b1, 1'b1});
    step();
    for (int i = 0; i < 15; i++) begin
      chk("ldm_wait", {State, MOV, RW, MDR_Ld}, {S_LDM, 3'b110});
      step();
    end
    MOC = 1'b1; #1;
    chk("ldm_moc", {State, MDR_Ld, MM}, {S_LDM, 1'b1, 1'b0});
    step();
    MOC = 1'b0; #1;
    chk("ldw_ctl", {State, MB, RF_Ld, OpXX}, {S_LDW, 2'b11, 1'b1, 6'b001110});
    step();
    chk("ld_adv", State, S_ADV);
    step();

    // ST r4,[r1+8] with MOC never arriving -> trap entry.
    fetch(32'hC8206008, 0);
    step();
    chk("st_lsa", State, S_LSA);
    step();
    chk("std_ctl", {State, MSa, MM, MDR_Ld, OpXX, MA}, {S_STD, 3'b111, 6'b001101, 2'b00});
    step();
    for (int i = 0; i < 16; i++) begin
      chk("stm_wait", {State, MOV, RW}, {S_STM, 2'b10});
      step();
    end
    chk("trap0_ctl", {State, MC, MSc, RF_Ld, MB}, {S_TRAP0, 1'b0, 2'b10, 1'b1, 2'b10});
    step();
    chk("trap1_ctl", {State, MC, MSc, RF_Ld}, {S_TRAP1, 1'b1, 2'b11, 1'b1});
    step();
    chk("trap2_ctl", {State, PC_Ld, MP, MA, NPC_Ld, MNP, OpXX}, {S_TRAP2, 1'b1, 2'b01, 2'b11, 1'b1, 2'b00, 6'b001101});
    step();
    chk("trap3_ctl", {State, NPC_Ld, MNP, PC_Ld}, {S_TRAP3, 1'b1, 2'b11, 1'b0});
    step();

    // BA,a taken
    fetch(32'h30800004, 1);
    BCOND = 1'b1;
    step();
    chk("ba_taken", {State, PC_Ld, MP, NPC_Ld, MNP}, {S_BR, 1'b1, 2'b11, 1'b1, 2'b10});
    step();
    BCOND = 1'b0;
    // BNE,a not taken -> annul
    fetch(32'h32800004, 0);
    step();
    chk("bne_annul", {State, MP, MNP}, {S_BR, 2'b10, 2'b01});
    step();

    // CALL
    fetch(32'h40000010, 0);
    step();
    chk("call0_ctl", {State, MSc, RF_Ld, MB, MC}, {S_CALL0, 2'b01, 1'b1, 2'b10, 1'b0});
    step();
    chk("call1_ctl", {State, MNP, MP, PC_Ld, NPC_Ld}, {S_CALL1, 2'b10, 2'b11, 2'b11});
    step();

    // SETHI
    fetch(32'h03000010, 0);
    step();
    chk("sethi_ctl", {State, MB, OpXX, RF_Ld}, {S_SETHI, 2'b01, 6'b001110, 1'b1});
    step(); step();

    // Ticc not taken, then taken
    fetch(32'h91D02000, 0);
    step();
    chk("ticc_state", State, S_TICC);
    step();
    chk("ticc_nt", State, S_ADV);
    step();
    fetch(32'h91D02000, 0);
    TCOND = 1'b1;
    step(); step();
    TCOND = 1'b0;
    chk("ticc_taken", State, S_TRAP0);
    step(); step(); step(); step();
    chk("ticc_back_f0", State, S_F0);

    // Unimplemented format-2 op2 traps; MOC in a non-memory state is ignored.
    fetch(32'h00000000, 0);
    MOC = 1'b1;
    step();
    MOC = 1'b0;
    chk("illegal_trap", {State, MOV}, {S_TRAP0, 1'b0});

    chk("const_zero", {RF_Clr, WIM_Ld, TTR_Ld, PSR_Ld, MF, typ}, 7'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
